// File: rtl/lab2_problem2_pkg.sv
// rtl/lab2_problem2_pkg.sv - shared opcode encoding and datapath width for the 4-bit ALU
package lab2_problem2_pkg;

    localparam int DATA_W = 4;

    typedef enum logic [2:0] {
        OP_NOT  = 3'b000,
        OP_ADD  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_ROTL = 3'b101,
        OP_CLR  = 3'b110,
        OP_SET  = 3'b111
    } opcode_e;

endpackage

// File: rtl/lab2_problem2_alu.sv
// rtl/lab2_problem2_alu.sv - combinational 8-operation ALU producing result and carry
import lab2_problem2_pkg::*;

module lab2_problem2_alu (
    input  logic [2:0]        Select,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              C,
    output logic [DATA_W-1:0] R,
    output logic              Cy
);

    logic [DATA_W:0] sum;

    // Five-bit sum so the carry out of bit 3 lands in the top bit.
    assign sum = {1'b0, A} + {1'b0, B} + {{DATA_W{1'b0}}, C};

    always_comb begin
        R  = '0;
        Cy = 1'b0;
        case (opcode_e'(Select))
            OP_NOT:  R = ~A;
            OP_ADD:  {Cy, R} = sum;
            OP_AND:  R = A & B;
            OP_OR:   R = A | B;
            OP_XOR:  R = A ^ B;
            OP_ROTL: begin
                R  = {A[DATA_W-2:0], C};
                Cy = A[DATA_W-1];
            end
            OP_CLR:  R = '0;
            OP_SET:  R = '1;
            default: R = '0;
        endcase
    end

endmodule

// File: rtl/lab2_problem2.sv
// rtl/lab2_problem2.sv - registered 4-bit ALU: combinational ALU into one output register stage
import lab2_problem2_pkg::*;

module lab2_problem2 (
    input  logic              clock,
    input  logic              reset,
    input  logic [2:0]        Select,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              C,
    output logic [DATA_W-1:0] RegOut,
    output logic              Carryout
);

    logic [DATA_W-1:0] reg_out_d, reg_out_q;
    logic              carry_d, carry_q;

    lab2_problem2_alu u_alu (
        .Select (Select),
        .A      (A),
        .B      (B),
        .C      (C),
        .R      (reg_out_d),
        .Cy     (carry_d)
    );

    // Every edge loads; reset clears asynchronously without waiting for the clock.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            reg_out_q <= '0;
            carry_q   <= 1'b0;
        end else begin
            reg_out_q <= reg_out_d;
            carry_q   <= carry_d;
        end
    end

    assign RegOut   = reg_out_q;
    assign Carryout = carry_q;

endmodule

// File: tb/tb_lab2_problem2.sv
// tb/tb_lab2_problem2.sv - scoreboard bench for the registered 4-bit ALU
module tb_lab2_problem2;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] Select = 3'b000;
    logic [3:0] A = 4'h0;
    logic [3:0] B = 4'h0;
    logic       C = 1'b0;
    logic [3:0] RegOut;
    logic       Carryout;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string      tag;
        logic [4:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];

    lab2_problem2 dut (
        .clock    (clock),
        .reset    (reset),
        .Select   (Select),
        .A        (A),
        .B        (B),
        .C        (C),
        .RegOut   (RegOut),
        .Carryout (Carryout)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish before 100000");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got {cy,r}=%b expected %b", tag, got, exp);
        end
    endtask

    // Reference written as plain integer arithmetic, independent of the RTL structure.
    function automatic logic [4:0] model(input logic [2:0] sel, input logic [3:0] a,
                                         input logic [3:0] b, input logic c);
        int s;
        case (sel)
            3'd0: return {1'b0, 4'hF - a};
            3'd1: begin
                s = int'(a) + int'(b) + int'(c);
                return {s >= 16, 4'(s % 16)};
            end
            3'd2: return {1'b0, a & b};
            3'd3: return {1'b0, a | b};
            3'd4: return {1'b0, a ^ b};
            3'd5: begin
                s = (int'(a) * 2 + int'(c)) % 16;
                return {a >= 4'd8, 4'(s)};
            end
            3'd6: return 5'b0_0000;
            default: return 5'b0_1111;
        endcase
    endfunction

    task automatic step(input string tag, input logic [2:0] sel, input logic [3:0] a,
                        input logic [3:0] b, input logic c, input logic [4:0] exp);
        sb_entry_t e;
        @(negedge clock);
        Select = sel; A = a; B = b; C = c;
        sb_q.push_back('{tag, exp});
        @(posedge clock);
        #1;
        e = sb_q.pop_front();
        check(e.tag, {Carryout, RegOut}, e.exp);
    endtask

    initial begin
        logic [3:0] vals [2];
        logic [2:0] rs;
        logic [3:0] ra, rb;
        logic       rc;
        logic [4:0] held;
        vals[0] = 4'h0;
        vals[1] = 4'hF;

        // Reset held with random inputs and a running clock.
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            Select = 3'($urandom); A = 4'($urandom); B = 4'($urandom); C = 1'($urandom);
            @(posedge clock);
            #1;
            check("reset_hold", {Carryout, RegOut}, 5'b0_0000);
        end

        @(negedge clock);
        reset = 1'b1;
        Select = 3'b000; A = 4'b0101; B = 4'h0; C = 1'b0;
        @(posedge clock);
        #1;
        check("reset_release_not", {Carryout, RegOut}, 5'b0_1010);

        step("add_5_5_0",    3'b001, 4'b0101, 4'b0101, 1'b0, 5'b0_1010);
        step("add_f_f_1",    3'b001, 4'b1111, 4'b1111, 1'b1, 5'b1_1111);
        step("add_0_0_1",    3'b001, 4'b0000, 4'b0000, 1'b1, 5'b0_0001);
        step("add_a_a_0",    3'b001, 4'b1010, 4'b1010, 1'b0, 5'b1_0100);

        for (int ia = 0; ia < 2; ia++) begin
            for (int ib = 0; ib < 2; ib++) begin
                step("and_sweep", 3'b010, vals[ia], vals[ib], 1'b1,
                     (ia == 1 && ib == 1) ? 5'b0_1111 : 5'b0_0000);
                step("or_sweep",  3'b011, vals[ia], vals[ib], 1'b1,
                     (ia == 0 && ib == 0) ? 5'b0_0000 : 5'b0_1111);
                step("xor_sweep", 3'b100, vals[ia], vals[ib], 1'b1,
                     (ia != ib) ? 5'b0_1111 : 5'b0_0000);
            end
        end

        step("rotl_1_c1",    3'b101, 4'b0001, 4'b0110, 1'b1, 5'b0_0011);
        step("rotl_f_c0",    3'b101, 4'b1111, 4'b0000, 1'b0, 5'b1_1110);
        step("rotl_8_c0",    3'b101, 4'b1000, 4'b1111, 1'b0, 5'b1_0000);
        step("clr",          3'b110, 4'b1111, 4'b1111, 1'b1, 5'b0_0000);
        step("set",          3'b111, 4'b0000, 4'b0000, 1'b0, 5'b0_1111);
        step("not_3",        3'b000, 4'b0011, 4'b1111, 1'b1, 5'b0_1100);

        // Inputs changed between edges must not reach the outputs until the next edge.
        step("mid_pre",      3'b100, 4'b1100, 4'b1010, 1'b0, 5'b0_0110);
        held = 5'b0_0110;
        @(negedge clock);
        Select = 3'b111; A = 4'h0; B = 4'h0; C = 1'b0;
        #2;
        check("mid_hold", {Carryout, RegOut}, held);
        Select = 3'b001; A = 4'h9; B = 4'h8; C = 1'b1;
        sb_q.push_back('{"mid_load", 5'b1_0010});
        #1;
        check("mid_hold2", {Carryout, RegOut}, held);
        @(posedge clock);
        #1;
        begin
            sb_entry_t e;
            e = sb_q.pop_front();
            check(e.tag, {Carryout, RegOut}, e.exp);
        end

        // Asynchronous reset between edges clears immediately.
        step("async_pre",    3'b111, 4'h0, 4'h0, 1'b0, 5'b0_1111);
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("async_clear", {Carryout, RegOut}, 5'b0_0000);
        @(posedge clock);
        #1;
        check("async_hold", {Carryout, RegOut}, 5'b0_0000);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 200; i++) begin
            rs = 3'($urandom); ra = 4'($urandom); rb = 4'($urandom); rc = 1'($urandom);
            step($sformatf("rand_op%0d_%h_%h_%b", rs, ra, rb, rc), rs, ra, rb, rc,
                 model(rs, ra, rb, rc));
        end

        check("sb_empty", 5'(sb_q.size()), 5'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
